src_queue_arb: RTL and testbench
================================

Name: src_queue_arb

Overview:
- Per-source request buffering and fair selection stage for N producers, e.g. load/store or refill requesters, feeding one shared consumer port.
- Each source has a private FIFO. A rotating-priority arbiter picks one non-empty FIFO per cycle and loads the winner into a registered output slot with a valid/ready handshake.
- The grant tag (`deq_src`) travels with the data so the consumer can route responses back to the right source.

Parameters:
- LG_N, 2, log2 of the number of sources; N = 1<<LG_N.
- LG_D, 2, log2 of per-source FIFO depth; D = 1<<LG_D.
- W, 64, payload width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- enq_valid  in  N  per-source request valid.
- enq_ready  out  N  per-source FIFO not full.
- enq_data  in  N*W  per-source payload; source i occupies bits [i*W +: W].
- deq_valid  out  1  output slot holds a request.
- deq_ready  in  1  consumer accepts the output this cycle.
- deq_data  out  W  payload of the output slot.
- deq_src  out  LG_N  source index of the output slot.
- q_empty  out  N  per-source FIFO empty, for debug and flush logic.

Behaviour:
- While rst=0: all FIFOs empty, the output slot is invalid and the rotate pointer is 0.
  - Outputs during reset: enq_ready=0, deq_valid=0, deq_data=0, deq_src=0, q_empty=all 1.
  - Reset asserted mid-operation drops all queued and slot contents with no drain.
- After rst rises: enq_ready=all 1 from the first cycle.
- Enqueue to source i occurs when enq_valid[i] & enq_ready[i] at the clock edge.
  - enq_ready[i] is purely registered state: count_i != D.
  - A full FIFO does not accept an enqueue even if it is popped the same cycle (no bypass).
- Per-FIFO state: wr_ptr, rd_ptr (LG_D bits each, wrap modulo D) and count (LG_D+1 bits, 0..D).
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
- Slot free: `slot_free = !deq_valid | deq_ready`.
- Arbitration is combinational each cycle over `req[i] = !q_empty[i]`.
  - Candidate order: r_ptr, r_ptr+1, …, r_ptr+N-1, all modulo N.
  - The first requesting source wins.
- When slot_free and any req:
  - Pop the winner's FIFO head into the slot.
  - deq_valid=1, deq_data=head, deq_src=winner.
  - r_ptr <= winner+1 (mod N).
- When slot_free and no req: deq_valid <= 0; r_ptr holds.
- When !slot_free: slot and r_ptr hold; no pop.
- Latency:
  - An enqueue at edge t into an empty system gives deq_valid=1 after edge t+1 (2 edges from enq_valid sample to deq_valid).
  - No enqueue-to-output bypass.
- Throughput: one dequeue per cycle sustained while deq_ready=1 and any FIFO is non-empty.
- Ordering:
  - Strict FIFO order within a source.
  - Across sources, each continuously requesting source wins at least once every N grants.
- deq_data and deq_src are stable while deq_valid=1 and deq_ready=0.
- Enqueue on a FIFO in the same cycle it is popped: both take effect; the new entry is not eligible until the next cycle.

Decomposition:
- Shared package `src_queue_pkg`:
  - localparams N and D derived from LG_N and LG_D.
  - typedef for the payload word (logic [W-1:0]).
  - typedef for the source index (logic [LG_N-1:0]).
- One sub-module, `src_fifo`:
  - Parameterised W and LG_D, same asynchronous active-low reset.
  - Ports: push/push_data, pop/head, full, empty.
  - Instantiated N times in a generate loop.
- Rotating-priority pick (rotate req by r_ptr, find first set, add r_ptr back modulo N) stays inline in the top module.

Test Plan:
- Reset mid-stream: fill source 1 with 3 entries, assert rst=0 for 1 cycle → deq_valid=0, q_empty=4'b1111, enq_ready=4'b1111 after release, nothing later dequeued.
- Single source latency: enqueue 0xA5 on source 2 at edge t, deq_ready=1 → deq_valid=1 with deq_data=0xA5, deq_src=2 after edge t+1; deq_valid=0 after edge t+2.
- Round robin: all 4 sources hold 2 entries, deq_ready=1 → deq_src sequence 0,1,2,3,0,1,2,3, each source's entries in enqueue order.
- Backpressure: output valid with deq_ready=0 for 5 cycles while sources enqueue → deq_data/deq_src unchanged, r_ptr unchanged; on release the next grant follows the stored pointer.
- Full: push 4 entries (D=4) into source 0 with deq_ready=0 → enq_ready[0]=0; push plus pop in the same cycle while full → no enqueue accepted, count drops to 3.
- Skip empty: only sources 1 and 3 non-empty, r_ptr=2 → grants 3 then 1, then r_ptr=2.

Source files
------------

// File: rtl/src_queue_pkg.sv
// Shared constants and types for the per-source request queue and arbiter.
// The top module and its bench take their default geometry from here.
package src_queue_pkg;

  localparam int LG_N = 2;
  localparam int LG_D = 2;
  localparam int W    = 64;
  localparam int N    = 1 << LG_N;
  localparam int D    = 1 << LG_D;

  typedef logic [W-1:0]    payload_t;
  typedef logic [LG_N-1:0] src_idx_t;

endpackage

// File: rtl/src_fifo.sv
// Single-source request FIFO: power-of-two depth, wrapping pointers, explicit count.
// Push is ignored while full and pop is ignored while empty.
module src_fifo #(
  parameter int W    = 64,
  parameter int LG_D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int D = 1 << LG_D;
  localparam logic [LG_D:0] DEPTH = {1'b1, {LG_D{1'b0}}};

  logic [W-1:0]    mem [D];
  logic [LG_D-1:0] wr_ptr;
  logic [LG_D-1:0] rd_ptr;
  logic [LG_D:0]   count;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/src_queue_arb.sv
// N private request FIFOs feeding one registered output slot through a rotating-priority
// arbiter; deq_src tags each request with the source it came from.
module src_queue_arb #(
  parameter int LG_N = src_queue_pkg::LG_N,
  parameter int LG_D = src_queue_pkg::LG_D,
  parameter int W    = src_queue_pkg::W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [(1<<LG_N)-1:0]  enq_valid,
  output logic [(1<<LG_N)-1:0]  enq_ready,
  input  logic [(1<<LG_N)*W-1:0] enq_data,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [W-1:0]          deq_data,
  output logic [LG_N-1:0]       deq_src,
  output logic [(1<<LG_N)-1:0]  q_empty
);

  localparam int N = 1 << LG_N;

  logic [N-1:0]    full;
  logic [N-1:0]    empty;
  logic [N-1:0]    req;
  logic [N-1:0]    rot;
  logic [N-1:0]    pop;
  logic [W-1:0]    head [N];
  logic [LG_N-1:0] r_ptr;
  logic [LG_N-1:0] first;
  logic [LG_N-1:0] winner;
  logic            any_req;
  logic            slot_free;
  logic            grant;

  // Gating with rst holds enq_ready low while reset is asserted and lets it rise with the release.
  assign enq_ready = ~full & {N{rst}};
  assign q_empty   = empty;
  assign req       = ~empty;
  assign any_req   = |req;
  assign slot_free = !deq_valid || deq_ready;
  assign grant     = slot_free && any_req;

  // Rotate so candidate r_ptr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) rot[i] = req[LG_N'(i) + r_ptr];
  end

  // NOTE: descending loop with blocking overwrite leaves the lowest set index; the default keeps it latch-free.
  always_comb begin
    first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) first = LG_N'(i);
    end
  end

  assign winner = first + r_ptr;

  for (genvar g = 0; g < N; g++) begin : g_src
    assign pop[g] = grant && (winner == LG_N'(g));

    src_fifo #(
      .W    (W),
      .LG_D (LG_D)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (enq_valid[g] && enq_ready[g]),
      .push_data (enq_data[g*W +: W]),
      .pop       (pop[g]),
      .head      (head[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deq_valid <= 1'b0;
      deq_data  <= '0;
      deq_src   <= '0;
      r_ptr     <= '0;
    end else if (slot_free) begin
      if (any_req) begin
        deq_valid <= 1'b1;
        deq_data  <= head[winner];
        deq_src   <= winner;
        r_ptr     <= winner + 1'b1;
      end else begin
        deq_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_src_queue_arb.sv
// Directed bench for src_queue_arb: a vector table for round-robin and latency,
// then hand-written sequences for backpressure, full, skip-empty and mid-stream reset.
module tb_src_queue_arb;
  import src_queue_pkg::*;

  logic             clk;
  logic             rst;
  logic [N-1:0]     enq_valid;
  logic [N-1:0]     enq_ready;
  logic [N*W-1:0]   enq_data;
  logic             deq_valid;
  logic             deq_ready;
  payload_t         deq_data;
  src_idx_t         deq_src;
  logic [N-1:0]     q_empty;

  int n_checks = 0;
  int n_fail   = 0;

  src_queue_arb #(.LG_N(LG_N), .LG_D(LG_D), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data),
    .deq_src   (deq_src),
    .q_empty   (q_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ev;
    logic [31:0] tags;
    logic        dr;
    logic        exp_valid;
    logic [1:0]  exp_src;
    logic [7:0]  exp_tag;
    logic [3:0]  exp_empty;
    logic [3:0]  exp_ready;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Source i gets payload {56'h0, tags[i*8 +: 8]}.
  task automatic drive(input logic [3:0] ev, input logic [31:0] tags, input logic dr);
    enq_valid = ev;
    for (int i = 0; i < N; i++) enq_data[i*W +: W] = {56'h0, tags[i*8 +: 8]};
    deq_ready = dr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [1:0] src, input logic [7:0] tag);
    check({name, " valid"}, 64'(deq_valid), 64'd1);
    check({name, " src"}, 64'(deq_src), 64'(src));
    check({name, " data"}, deq_data, {56'h0, tag});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'b1111, 32'h13121110, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b1111};
    vecs[1]  = '{4'b1111, 32'h23222120, 1'b0, 1'b1, 2'd0, 8'h10, 4'b0000, 4'b1111};
    vecs[2]  = '{4'b0000, 32'h0,        1'b1, 1'b1, 2'd1, 8'h11, 4'b0000, 4'b1111};
    vecs[3]  = '{4'b0000, 32'h0,        1'b1, 1'b1, 2'd2, 8'h12, 4'b0000, 4'b1111};
    vecs[4]  = '{4'b0000, 32'h0,        1'b1, 1'b1, 2'd3, 8'h13, 4'b0000, 4'b1111};
    vecs[5]  = '{4'b0000, 32'h0,        1'b1, 1'b1, 2'd0, 8'h20, 4'b0001, 4'b1111};
    vecs[6]  = '{4'b0000, 32'h0,        1'b1, 1'b1, 2'd1, 8'h21, 4'b0011, 4'b1111};
    vecs[7]  = '{4'b0000, 32'h0,        1'b1, 1'b1, 2'd2, 8'h22, 4'b0111, 4'b1111};
    vecs[8]  = '{4'b0000, 32'h0,        1'b1, 1'b1, 2'd3, 8'h23, 4'b1111, 4'b1111};
    vecs[9]  = '{4'b0000, 32'h0,        1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 4'b1111};
    vecs[10] = '{4'b0100, 32'h00A50000, 1'b1, 1'b0, 2'd0, 8'h00, 4'b1011, 4'b1111};
    vecs[11] = '{4'b0000, 32'h0,        1'b1, 1'b1, 2'd2, 8'hA5, 4'b1111, 4'b1111};
    vecs[12] = '{4'b0000, 32'h0,        1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 4'b1111};

    rst = 1'b0;
    drive(4'b0000, 32'h0, 1'b0);
    #2;
    check("reset enq_ready", 64'(enq_ready), 64'h0);
    check("reset deq_valid", 64'(deq_valid), 64'h0);
    check("reset deq_data", deq_data, 64'h0);
    check("reset deq_src", 64'(deq_src), 64'h0);
    check("reset q_empty", 64'(q_empty), 64'hF);
    step();
    rst = 1'b1;
    #1;
    check("release enq_ready", 64'(enq_ready), 64'hF);

    // Round robin over four loaded sources, then single-source latency.
    for (int v = 0; v < 13; v++) begin
      drive(vecs[v].ev, vecs[v].tags, vecs[v].dr);
      step();
      check($sformatf("vec%0d valid", v), 64'(deq_valid), 64'(vecs[v].exp_valid));
      check($sformatf("vec%0d q_empty", v), 64'(q_empty), 64'(vecs[v].exp_empty));
      check($sformatf("vec%0d enq_ready", v), 64'(enq_ready), 64'(vecs[v].exp_ready));
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d src", v), 64'(deq_src), 64'(vecs[v].exp_src));
        check($sformatf("vec%0d data", v), deq_data, {56'h0, vecs[v].exp_tag});
      end
    end

    // Backpressure: slot holds src0 while sources 2 and 3 keep enqueuing.
    drive(4'b0011, 32'h00003130, 1'b0);
    step();
    drive(4'b0000, 32'h0, 1'b0);
    step();
    expect_out("bp load", 2'd0, 8'h30);
    for (int k = 0; k < 5; k++) begin
      drive(4'b1100, 32'h43420000, 1'b0);
      step();
      expect_out($sformatf("bp hold%0d", k), 2'd0, 8'h30);
    end
    check("bp enq_ready", 64'(enq_ready), 64'h3);
    drive(4'b0000, 32'h0, 1'b1);
    step();
    expect_out("bp release", 2'd1, 8'h31);
    step();
    expect_out("bp next", 2'd2, 8'h42);
    for (int k = 0; k < 8; k++) step();
    check("bp drained valid", 64'(deq_valid), 64'h0);
    check("bp drained q_empty", 64'(q_empty), 64'hF);

    // Full: fill source 0 behind a stalled slot, then push+pop while full.
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, {24'h0, 8'h50 + 8'(k)}, 1'b0);
      step();
    end
    check("full enq_ready", 64'(enq_ready), 64'hE);
    expect_out("full slot", 2'd0, 8'h50);
    drive(4'b0001, 32'h00000055, 1'b1);
    step();
    expect_out("full pop", 2'd0, 8'h51);
    check("full pop enq_ready", 64'(enq_ready), 64'hF);
    check("full pop q_empty", 64'(q_empty), 64'hE);
    drive(4'b0000, 32'h0, 1'b1);
    step();
    expect_out("full drain0", 2'd0, 8'h52);
    step();
    expect_out("full drain1", 2'd0, 8'h53);
    step();
    expect_out("full drain2", 2'd0, 8'h54);
    step();
    check("full no extra", 64'(deq_valid), 64'h0);

    // Skip empty: move r_ptr to 2, then only sources 1 and 3 request.
    drive(4'b0010, 32'h00006000, 1'b1);
    step();
    drive(4'b0000, 32'h0, 1'b1);
    step();
    expect_out("skip setup", 2'd1, 8'h60);
    step();
    check("skip setup idle", 64'(deq_valid), 64'h0);
    drive(4'b1010, 32'h73007100, 1'b1);
    step();
    check("skip q_empty", 64'(q_empty), 64'h5);
    drive(4'b0000, 32'h0, 1'b1);
    step();
    expect_out("skip first", 2'd3, 8'h73);
    step();
    expect_out("skip second", 2'd1, 8'h71);
    step();
    check("skip idle", 64'(deq_valid), 64'h0);
    drive(4'b0101, 32'h00820080, 1'b1);
    step();
    drive(4'b0000, 32'h0, 1'b1);
    step();
    expect_out("skip ptr2", 2'd2, 8'h82);
    step();
    expect_out("skip ptr0", 2'd0, 8'h80);

    // Mid-stream reset drops queued entries and the slot.
    for (int k = 0; k < 3; k++) begin
      drive(4'b0010, {16'h0, 8'h91 + 8'(k), 8'h0}, 1'b0);
      step();
    end
    check("pre-reset q_empty", 64'(q_empty), 64'hD);
    drive(4'b0000, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    check("mid reset valid", 64'(deq_valid), 64'h0);
    check("mid reset q_empty", 64'(q_empty), 64'hF);
    check("mid reset enq_ready", 64'(enq_ready), 64'h0);
    check("mid reset data", deq_data, 64'h0);
    check("mid reset src", 64'(deq_src), 64'h0);
    step();
    rst = 1'b1;
    #1;
    check("post reset enq_ready", 64'(enq_ready), 64'hF);
    check("post reset q_empty", 64'(q_empty), 64'hF);
    drive(4'b0000, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("post reset idle%0d", k), 64'(deq_valid), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
